// File: rtl/sort_floats_seq_controller.sv
// ---------------------------------------------------------------------------
// sort_floats_seq_controller
//
// Purpose:
//   Sorts a job of N floating-point operands into ascending order with a
//   sequential bubble sort. A single f_less_or_equal comparator is reused for
//   every comparison of the job. One comparison, and possibly one swap, is
//   made per clock cycle.
//
// Ports:
//   clk        in   single clock, all state updates on its rising edge
//   rst        in   asynchronous, active-high reset
//   up_valid   in   a job is presented on unsorted
//   up_ready   out  block can accept a job (high only in IDLE)
//   unsorted   in   [0:N-1][FLEN-1:0] job operands
//   down_valid out  sorted and err are valid (high only in DONE)
//   down_ready in   consumer takes the result
//   sorted     out  [0:N-1][FLEN-1:0] result, sorted[0] smallest
//   err        out  sticky OR of comparator err over the whole job
//
// Configuration:
//   SORT_FLOATS_FLEN           float width; defaults to 64 (FP64) when the
//                              shared config header has not defined it.
//   SORT_FLOATS_EARLY_EXIT_EN  when defined, a pass that makes no swap ends
//                              the job early. When undefined, every job takes
//                              exactly N*(N-1)/2 compare cycles.
// ---------------------------------------------------------------------------

`ifndef SORT_FLOATS_FLEN
`define SORT_FLOATS_FLEN 64
`endif

// ---------------------------------------------------------------------------
// f_less_or_equal
//
// Purpose:
//   IEEE-754 a <= b for one FLEN-bit format (16, 32 or 64 bits).
//   -0 and +0 compare equal. Any NaN operand makes the result false and
//   raises err (signalling comparison).
//
// Ports:
//   a, b  in   operands
//   res   out  1 when a <= b
//   err   out  1 when either operand is a NaN
// ---------------------------------------------------------------------------
module f_less_or_equal #(
    parameter int FLEN = 64
) (
    input  logic [FLEN-1:0] a,
    input  logic [FLEN-1:0] b,
    output logic            res,
    output logic            err
);
    localparam int EW = (FLEN == 64) ? 11 : (FLEN == 32) ? 8 : 5;
    localparam int MW = FLEN - 1 - EW;

    logic            a_sign;
    logic            b_sign;
    logic [FLEN-2:0] a_mag;
    logic [FLEN-2:0] b_mag;
    logic            a_nan;
    logic            b_nan;

    assign a_sign = a[FLEN-1];
    assign b_sign = b[FLEN-1];
    assign a_mag  = a[FLEN-2:0];
    assign b_mag  = b[FLEN-2:0];
    assign a_nan  = (&a[FLEN-2:MW]) && (|a[MW-1:0]);
    assign b_nan  = (&b[FLEN-2:MW]) && (|b[MW-1:0]);

    always_comb begin
        err = a_nan || b_nan;
        res = 1'b0;
        if (a_nan || b_nan) begin
            res = 1'b0;
        end else if ((a_mag == '0) && (b_mag == '0)) begin
            // +0 and -0 are equal whatever their signs
            res = 1'b1;
        end else if (a_sign != b_sign) begin
            res = a_sign;
        end else if (!a_sign) begin
            res = (a_mag <= b_mag);
        end else begin
            // both negative: larger magnitude is the smaller value
            res = (a_mag >= b_mag);
        end
    end
endmodule

module sort_floats_seq_controller #(
    parameter  int N    = 4,
    localparam int FLEN = `SORT_FLOATS_FLEN
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      up_valid,
    output logic                      up_ready,
    input  logic [0:N-1][FLEN-1:0]    unsorted,
    output logic                      down_valid,
    input  logic                      down_ready,
    output logic [0:N-1][FLEN-1:0]    sorted,
    output logic                      err
);
    // Index width holds 0..N-1 so that j+1 is representable.
    localparam int             IW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0]  JMAX = IW'(N - 2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;

    logic [FLEN-1:0] work_reg  [N];
    logic [FLEN-1:0] work_next [N];
    logic            err_reg;
    logic [IW-1:0]   pass_reg;
    logic [IW-1:0]   j_reg;
    logic [IW-1:0]   j_plus1;

    logic [FLEN-1:0] cmp_a;
    logic [FLEN-1:0] cmp_b;
    logic            cmp_res;
    logic            cmp_err;

    logic            load;
    logic            in_compare;
    logic            do_swap;
    logic            last_j;
    logic            last_pass;
    logic            job_end;

    // -----------------------------------------------------------------------
    // Shared comparator on the current adjacent pair
    // -----------------------------------------------------------------------
    assign j_plus1 = j_reg + 1'b1;
    assign cmp_a   = work_reg[j_reg];
    assign cmp_b   = work_reg[j_plus1];

    f_less_or_equal #(
        .FLEN (FLEN)
    ) u_cmp (
        .a   (cmp_a),
        .b   (cmp_b),
        .res (cmp_res),
        .err (cmp_err)
    );

    assign load       = (state_reg == IDLE) && up_valid;
    assign in_compare = (state_reg == COMPARE);
    // Swap only on a strict "not <=" so equal values keep their order; an
    // err comparison still follows res.
    assign do_swap    = in_compare && !cmp_res;
    assign last_j     = (j_reg == (JMAX - pass_reg));
    assign last_pass  = (pass_reg == JMAX);

`ifdef SORT_FLOATS_EARLY_EXIT_EN
    logic swapped_reg;

    // The pass is clean only if neither earlier compares nor this one swapped.
    assign job_end = last_j && (last_pass || (!swapped_reg && !do_swap));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            swapped_reg <= 1'b0;
        end else if (load) begin
            swapped_reg <= 1'b0;
        end else if (in_compare) begin
            if (last_j) begin
                swapped_reg <= 1'b0;
            end else if (do_swap) begin
                swapped_reg <= 1'b1;
            end
        end
    end
`else
    assign job_end = last_j && last_pass;
`endif

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (up_valid) begin
                    state_next = COMPARE;
                end
            end
            COMPARE: begin
                if (in_compare && job_end) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (down_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        up_ready   = 1'b0;
        down_valid = 1'b0;
        case (state_reg)
            IDLE:    up_ready   = 1'b1;
            DONE:    down_valid = 1'b1;
            default: begin
                up_ready   = 1'b0;
                down_valid = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Working registers: load on accept, swap the compared pair in COMPARE
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < N; gi++) begin : g_work
        assign work_next[gi] =
            load                                ? unsorted[gi] :
            (do_swap && (j_reg   == IW'(gi)))   ? cmp_b        :
            (do_swap && (j_plus1 == IW'(gi)))   ? cmp_a        :
                                                  work_reg[gi];

        assign sorted[gi] = work_reg[gi];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                work_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                work_reg[k] <= work_next[k];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Pass / index counters and sticky err
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg  <= 1'b0;
            pass_reg <= '0;
            j_reg    <= '0;
        end else if (load) begin
            err_reg  <= 1'b0;
            pass_reg <= '0;
            j_reg    <= '0;
        end else if (in_compare) begin
            err_reg <= err_reg | cmp_err;
            if (last_j) begin
                j_reg <= '0;
                // Counters are reloaded on the next accept, so the value left
                // after the final pass does not matter.
                if (!job_end) begin
                    pass_reg <= pass_reg + 1'b1;
                end
            end else begin
                j_reg <= j_plus1;
            end
        end
    end

    assign err = err_reg;

endmodule

// File: tb/tb_sort_floats_seq_controller.sv
module tb_sort_floats_seq_controller;
    localparam int N = 4;

`ifdef SORT_FLOATS_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam logic [63:0] F_ONE   = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] F_TWO   = 64'h4000_0000_0000_0000;
    localparam logic [63:0] F_THREE = 64'h4008_0000_0000_0000;
    localparam logic [63:0] F_FOUR  = 64'h4010_0000_0000_0000;
    localparam logic [63:0] F_MONE  = 64'hBFF0_0000_0000_0000;
    localparam logic [63:0] F_QNAN  = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] F_PZERO = 64'h0000_0000_0000_0000;
    localparam logic [63:0] F_NZERO = 64'h8000_0000_0000_0000;
    localparam logic [63:0] F_PINF  = 64'h7FF0_0000_0000_0000;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   up_valid = 1'b0;
    logic                   up_ready;
    logic [0:N-1][63:0]     unsorted = '0;
    logic                   down_valid;
    logic                   down_ready = 1'b0;
    logic [0:N-1][63:0]     sorted;
    logic                   err;

    int checks   = 0;
    int failures = 0;
    int job_no   = 0;

    always #5 clk = ~clk;

    sort_floats_seq_controller #(
        .N (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .unsorted   (unsorted),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .sorted     (sorted),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_nan(input logic [63:0] x);
        return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
    endfunction

    // Bubble sort on real values: adjacent pair swapped when a <= b is false.
    function automatic void model(input logic [0:N-1][63:0] v,
                                  output logic [0:N-1][63:0] s,
                                  output logic e, output int k);
        s = v;
        e = 1'b0;
        k = 0;
        for (int p = 0; p <= N - 2; p++) begin
            bit sw;
            sw = 1'b0;
            for (int jj = 0; jj <= N - 2 - p; jj++) begin
                logic [63:0] a;
                logic [63:0] b;
                a = s[jj];
                b = s[jj+1];
                k++;
                if (is_nan(a) || is_nan(b)) e = 1'b1;
                if (!($bitstoreal(a) <= $bitstoreal(b))) begin
                    s[jj]   = b;
                    s[jj+1] = a;
                    sw      = 1'b1;
                end
            end
            if (EARLY && !sw) break;
        end
    endfunction

    function automatic logic [63:0] rand_float();
        case ($urandom_range(0, 11))
            0:  return F_ONE;
            1:  return F_TWO;
            2:  return F_THREE;
            3:  return F_FOUR;
            4:  return F_MONE;
            5:  return F_QNAN;
            6:  return F_PZERO;
            7:  return F_NZERO;
            8:  return F_PINF;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // Called at a negedge with the DUT in IDLE. hold = cycles of down_ready=0
    // in DONE; up_valid stays high until the result handshake.
    task automatic run_job(input logic [0:N-1][63:0] v, input int hold);
        logic [0:N-1][63:0] exp_s;
        logic               exp_e;
        int                 exp_k;
        int                 cnt;
        model(v, exp_s, exp_e, exp_k);
        unsorted   = v;
        up_valid   = 1'b1;
        down_ready = (hold == 0);
        chk("up_ready_idle", {63'd0, up_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        cnt = 0;
        while (!down_valid && cnt < 100) begin
            chk("up_ready_busy", {63'd0, up_ready}, 64'd0);
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        chk("latency", 64'(cnt), 64'(exp_k));
        for (int i = 0; i < N; i++) chk($sformatf("sorted[%0d]", i), sorted[i], exp_s[i]);
        chk("err", {63'd0, err}, {63'd0, exp_e});
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", {63'd0, down_valid}, 64'd1);
            chk("hold_up_ready", {63'd0, up_ready}, 64'd0);
            chk("hold_err", {63'd0, err}, {63'd0, exp_e});
            for (int i = 0; i < N; i++) chk("hold_sorted", sorted[i], exp_s[i]);
        end
        down_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_hs_valid", {63'd0, down_valid}, 64'd0);
        chk("post_hs_up_ready", {63'd0, up_ready}, 64'd1);
        up_valid   = 1'b0;
        down_ready = 1'b0;
        $display("job %0d: in=%h %h %h %h out=%h %h %h %h err=%0b cycles=%0d", job_no,
                 v[0], v[1], v[2], v[3], sorted[0], sorted[1], sorted[2], sorted[3], err, cnt);
        job_no++;
    endtask

    task automatic abort_job(input logic [0:N-1][63:0] v);
        bit seen;
        unsorted = v;
        up_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        up_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk("abort_up_ready", {63'd0, up_ready}, 64'd1);
        chk("abort_valid", {63'd0, down_valid}, 64'd0);
        chk("abort_err", {63'd0, err}, 64'd0);
        for (int i = 0; i < N; i++) chk("abort_sorted", sorted[i], 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            seen |= down_valid;
        end
        chk("abort_no_valid", {63'd0, seen}, 64'd0);
        $display("job %0d: aborted by reset", job_no);
        job_no++;
    endtask

    initial begin
        logic [0:N-1][63:0] v;
        #1;
        chk("rst_up_ready", {63'd0, up_ready}, 64'd1);
        chk("rst_valid", {63'd0, down_valid}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        for (int i = 0; i < N; i++) chk("rst_sorted", sorted[i], 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reverse order
        v = {F_FOUR, F_THREE, F_TWO, F_ONE};
        run_job(v, 0);
        // Sorted with duplicates
        v = {F_MONE, F_ONE, F_ONE, F_THREE};
        run_job(v, 0);
        // NaN, then clean job clears err
        v = {F_ONE, F_QNAN, F_TWO, F_THREE};
        run_job(v, 1);
        v = {F_TWO, F_ONE, F_THREE, F_FOUR};
        run_job(v, 0);
        // Backpressure for 5 cycles with up_valid held high
        v = {F_THREE, F_MONE, F_NZERO, F_PZERO};
        run_job(v, 5);
        // Reset on the 3rd compare cycle, then a fresh job
        v = {F_FOUR, F_THREE, F_TWO, F_ONE};
        abort_job(v);
        v = {F_THREE, F_ONE, F_TWO, F_FOUR};
        run_job(v, 0);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) v[i] = rand_float();
            run_job(v, $urandom_range(0, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
